// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator for the TinyQV VGA
// console. The default mode is 1024x768@60 CVT at a 64 MHz pixel clock.
// Optional feature macro: SCANLINE_IRQ_EN (line-compare interrupt).
//
// Ports:
//   clk, rst_n       pixel clock, async active-low reset
//   en               timing enable; low restarts the raster at (0,0)
//   irq_clr          one-cycle pulse clearing frame_irq / line_irq
//   line_cmp         line-compare value (used only with SCANLINE_IRQ_EN)
//   x, y             current pixel column / line
//   x_cell, x_sub    column cell index / pixel within cell
//   y_cell, y_sub    row cell index / line within cell
//   hsync, vsync     sync outputs at H_POL / V_POL active level
//   blank            1 outside the active area
//   frame_cnt        frames completed, wraps
//   frame_irq        latched start-of-vblank interrupt
//   line_irq         latched line-compare interrupt
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 104,
    parameter int unsigned H_BP     = 152,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b1,
    parameter int unsigned X_CELL   = 32,
    parameter int unsigned Y_CELL   = 48,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL),
    localparam int unsigned XCW     = $clog2(H_TOTAL / X_CELL + 1),
    localparam int unsigned YCW     = $clog2(V_TOTAL / Y_CELL + 1),
    localparam int unsigned XSW     = $clog2(X_CELL),
    localparam int unsigned YSW     = $clog2(Y_CELL)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           irq_clr,
    input  logic [YW-1:0]  line_cmp,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic [XCW-1:0] x_cell,
    output logic [XSW-1:0] x_sub,
    output logic [YCW-1:0] y_cell,
    output logic [YSW-1:0] y_sub,
    output logic           hsync,
    output logic           vsync,
    output logic           blank,
    output logic [7:0]     frame_cnt,
    output logic           frame_irq,
    output logic           line_irq
);

    localparam logic [XW-1:0]  X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]  Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [XSW-1:0] X_SUB_LAST = XSW'(X_CELL - 1);
    localparam logic [YSW-1:0] Y_SUB_LAST = YSW'(Y_CELL - 1);
    localparam logic [YW-1:0]  Y_VBLANK   = YW'(V_ACTIVE);
    localparam int unsigned    HS_START   = H_ACTIVE + H_FP;
    localparam int unsigned    HS_END     = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned    VS_START   = V_ACTIVE + V_FP;
    localparam int unsigned    VS_END     = V_ACTIVE + V_FP + V_SYNC;

    logic [XW-1:0]  x_nxt;
    logic [YW-1:0]  y_nxt;
    logic [XCW-1:0] x_cell_nxt;
    logic [XSW-1:0] x_sub_nxt;
    logic [YCW-1:0] y_cell_nxt;
    logic [YSW-1:0] y_sub_nxt;
    logic           hsync_nxt;
    logic           vsync_nxt;
    logic           blank_nxt;
    logic           frame_evt;

    always_comb begin
        x_nxt      = x;
        y_nxt      = y;
        x_cell_nxt = x_cell;
        x_sub_nxt  = x_sub;
        y_cell_nxt = y_cell;
        y_sub_nxt  = y_sub;
        if (!en) begin
            x_nxt      = '0;
            y_nxt      = '0;
            x_cell_nxt = '0;
            x_sub_nxt  = '0;
            y_cell_nxt = '0;
            y_sub_nxt  = '0;
        end else if (x == X_LAST) begin
            x_nxt      = '0;
            x_cell_nxt = '0;
            x_sub_nxt  = '0;
            if (y == Y_LAST) begin
                y_nxt      = '0;
                y_cell_nxt = '0;
                y_sub_nxt  = '0;
            end else begin
                y_nxt = y + YW'(1);
                if (y_sub == Y_SUB_LAST) begin
                    y_sub_nxt  = '0;
                    y_cell_nxt = y_cell + YCW'(1);
                end else begin
                    y_sub_nxt = y_sub + YSW'(1);
                end
            end
        end else begin
            x_nxt = x + XW'(1);
            if (x_sub == X_SUB_LAST) begin
                x_sub_nxt  = '0;
                x_cell_nxt = x_cell + XCW'(1);
            end else begin
                x_sub_nxt = x_sub + XSW'(1);
            end
        end

        // Decoding from the next-state counters keeps the registered
        // sync/blank aligned with the registered x/y of the same pixel.
        hsync_nxt = ((32'(x_nxt) >= HS_START) && (32'(x_nxt) < HS_END)) ? H_POL : ~H_POL;
        vsync_nxt = ((32'(y_nxt) >= VS_START) && (32'(y_nxt) < VS_END)) ? V_POL : ~V_POL;
        blank_nxt = (32'(x_nxt) >= H_ACTIVE) || (32'(y_nxt) >= V_ACTIVE);
        frame_evt = en && (x_nxt == '0) && (y_nxt == Y_VBLANK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            x_cell    <= '0;
            x_sub     <= '0;
            y_cell    <= '0;
            y_sub     <= '0;
            hsync     <= ~H_POL;
            vsync     <= ~V_POL;
            blank     <= 1'b0;
            frame_cnt <= '0;
            frame_irq <= 1'b0;
        end else begin
            x      <= x_nxt;
            y      <= y_nxt;
            x_cell <= x_cell_nxt;
            x_sub  <= x_sub_nxt;
            y_cell <= y_cell_nxt;
            y_sub  <= y_sub_nxt;
            hsync  <= hsync_nxt;
            vsync  <= vsync_nxt;
            blank  <= blank_nxt;
            if (frame_evt) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            // A new event takes priority over a coincident clear.
            if (frame_evt) begin
                frame_irq <= 1'b1;
            end else if (irq_clr) begin
                frame_irq <= 1'b0;
            end
        end
    end

`ifdef SCANLINE_IRQ_EN
    logic line_hit;
    assign line_hit = en && (x_nxt == '0) && (y_nxt == line_cmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_irq <= 1'b0;
        end else if (line_hit) begin
            line_irq <= 1'b1;
        end else if (irq_clr) begin
            line_irq <= 1'b0;
        end
    end
`else
    logic unused_line_cmp;
    assign unused_line_cmp = ^line_cmp;
    assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-mode instance for line-level timing
// and a small-mode instance (25x18 total) for frame, cell, irq and enable.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic irq_clr;
    logic en_d, en_s;
    logic [9:0] line_cmp_d;
    logic [4:0] line_cmp_s;

    logic [10:0] d_x;  logic [9:0] d_y;
    logic [5:0]  d_x_cell; logic [4:0] d_x_sub;
    logic [4:0]  d_y_cell; logic [5:0] d_y_sub;
    logic d_hsync, d_vsync, d_blank, d_frame_irq, d_line_irq;
    logic [7:0] d_frame_cnt;

    logic [4:0] s_x, s_y;
    logic [2:0] s_x_cell, s_y_cell;
    logic [1:0] s_x_sub, s_y_sub;
    logic s_hsync, s_vsync, s_blank, s_frame_irq, s_line_irq;
    logic [7:0] s_frame_cnt;

    int checks = 0;
    int errors = 0;

`ifdef SCANLINE_IRQ_EN
    localparam bit LI = 1'b1;
`else
    localparam bit LI = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .en(en_d), .irq_clr(irq_clr), .line_cmp(line_cmp_d),
        .x(d_x), .y(d_y), .x_cell(d_x_cell), .x_sub(d_x_sub),
        .y_cell(d_y_cell), .y_sub(d_y_sub), .hsync(d_hsync), .vsync(d_vsync),
        .blank(d_blank), .frame_cnt(d_frame_cnt), .frame_irq(d_frame_irq),
        .line_irq(d_line_irq)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b0), .X_CELL(4), .Y_CELL(4)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en_s), .irq_clr(irq_clr), .line_cmp(line_cmp_s),
        .x(s_x), .y(s_y), .x_cell(s_x_cell), .x_sub(s_x_sub),
        .y_cell(s_y_cell), .y_sub(s_y_sub), .hsync(s_hsync), .vsync(s_vsync),
        .blank(s_blank), .frame_cnt(s_frame_cnt), .frame_irq(s_frame_irq),
        .line_irq(s_line_irq)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        checks++; if (d_x !== 11'd5) begin errors++; $display("FAIL pre_reset_x: got %0d want 5", d_x); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (d_x !== 11'd0 || d_y !== 10'd0 || d_x_sub !== 5'd0 || d_x_cell !== 6'd0) begin
            errors++; $display("FAIL reset_counters_d: x=%0d y=%0d sub=%0d cell=%0d want 0", d_x, d_y, d_x_sub, d_x_cell); end
        checks++; if (d_hsync !== 1'b1 || d_vsync !== 1'b0 || d_blank !== 1'b0) begin
            errors++; $display("FAIL reset_sync_d: hs=%b vs=%b bl=%b want 1 0 0", d_hsync, d_vsync, d_blank); end
        checks++; if (s_x !== 5'd0 || s_hsync !== 1'b0 || s_vsync !== 1'b1 || s_frame_cnt !== 8'd0 || s_frame_irq !== 1'b0 || s_line_irq !== 1'b0) begin
            errors++; $display("FAIL reset_s: x=%0d hs=%b vs=%b fc=%0d fi=%b li=%b want 0 0 1 0 0 0",
                               s_x, s_hsync, s_vsync, s_frame_cnt, s_frame_irq, s_line_irq); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1);
        checks++; if (d_x !== 11'd1) begin errors++; $display("FAIL release_x1: got %0d want 1", d_x); end
        cyc(1);
        checks++; if (d_x !== 11'd2) begin errors++; $display("FAIL release_x2: got %0d want 2", d_x); end
    endtask

    task automatic test_hline;
        cyc(1021);
        checks++; if (d_blank !== 1'b0 || d_hsync !== 1'b1) begin
            errors++; $display("FAIL d_x1023: bl=%b hs=%b want 0 1", d_blank, d_hsync); end
        cyc(1);
        checks++; if (d_blank !== 1'b1) begin errors++; $display("FAIL d_blank_1024: got %b want 1", d_blank); end
        cyc(47);
        checks++; if (d_hsync !== 1'b1) begin errors++; $display("FAIL d_hs_1071: got %b want 1", d_hsync); end
        cyc(1);
        checks++; if (d_hsync !== 1'b0) begin errors++; $display("FAIL d_hs_1072: got %b want 0", d_hsync); end
        cyc(103);
        checks++; if (d_hsync !== 1'b0) begin errors++; $display("FAIL d_hs_1175: got %b want 0", d_hsync); end
        cyc(1);
        checks++; if (d_hsync !== 1'b1) begin errors++; $display("FAIL d_hs_1176: got %b want 1", d_hsync); end
        cyc(151);
        checks++; if (d_x !== 11'd1327 || d_y !== 10'd0 || d_x_cell !== 6'd41 || d_x_sub !== 5'd15) begin
            errors++; $display("FAIL d_x1327: x=%0d y=%0d cell=%0d sub=%0d want 1327 0 41 15", d_x, d_y, d_x_cell, d_x_sub); end
        cyc(1);
        checks++; if (d_x !== 11'd0 || d_y !== 10'd1 || d_x_cell !== 6'd0 || d_blank !== 1'b0 || d_vsync !== 1'b0) begin
            errors++; $display("FAIL d_wrap: x=%0d y=%0d cell=%0d bl=%b vs=%b want 0 1 0 0 0", d_x, d_y, d_x_cell, d_blank, d_vsync); end
        cyc(31);
        checks++; if (d_x_sub !== 5'd31 || d_x_cell !== 6'd0) begin
            errors++; $display("FAIL d_x31: sub=%0d cell=%0d want 31 0", d_x_sub, d_x_cell); end
        cyc(1);
        checks++; if (d_x_sub !== 5'd0 || d_x_cell !== 6'd1) begin
            errors++; $display("FAIL d_x32: sub=%0d cell=%0d want 0 1", d_x_sub, d_x_cell); end
    endtask

    task automatic test_small_frame;
        line_cmp_s = 5'd5;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;                                   // k = 0
        cyc(3);
        checks++; if (s_x !== 5'd3 || s_x_sub !== 2'd3 || s_x_cell !== 3'd0) begin
            errors++; $display("FAIL s_x3: x=%0d sub=%0d cell=%0d want 3 3 0", s_x, s_x_sub, s_x_cell); end
        cyc(1);
        checks++; if (s_x_sub !== 2'd0 || s_x_cell !== 3'd1) begin
            errors++; $display("FAIL s_x4: sub=%0d cell=%0d want 0 1", s_x_sub, s_x_cell); end
        cyc(11);
        checks++; if (s_blank !== 1'b0 || s_hsync !== 1'b0) begin
            errors++; $display("FAIL s_x15: bl=%b hs=%b want 0 0", s_blank, s_hsync); end
        cyc(1);
        checks++; if (s_blank !== 1'b1 || s_hsync !== 1'b0) begin
            errors++; $display("FAIL s_x16: bl=%b hs=%b want 1 0", s_blank, s_hsync); end
        cyc(1);
        checks++; if (s_hsync !== 1'b0) begin errors++; $display("FAIL s_hs17: got %b want 0", s_hsync); end
        cyc(1);
        checks++; if (s_hsync !== 1'b1) begin errors++; $display("FAIL s_hs18: got %b want 1", s_hsync); end
        cyc(2);
        checks++; if (s_hsync !== 1'b1) begin errors++; $display("FAIL s_hs20: got %b want 1", s_hsync); end
        cyc(1);
        checks++; if (s_hsync !== 1'b0) begin errors++; $display("FAIL s_hs21: got %b want 0", s_hsync); end
        cyc(3);                                         // k = 24, partial last cell
        checks++; if (s_x !== 5'd24 || s_x_cell !== 3'd6 || s_x_sub !== 2'd0 || s_y !== 5'd0) begin
            errors++; $display("FAIL s_x24: x=%0d cell=%0d sub=%0d y=%0d want 24 6 0 0", s_x, s_x_cell, s_x_sub, s_y); end
        cyc(1);
        checks++; if (s_x !== 5'd0 || s_y !== 5'd1 || s_x_cell !== 3'd0) begin
            errors++; $display("FAIL s_wrap: x=%0d y=%0d cell=%0d want 0 1 0", s_x, s_y, s_x_cell); end
        cyc(50);                                        // k = 75
        checks++; if (s_y !== 5'd3 || s_y_sub !== 2'd3 || s_y_cell !== 3'd0) begin
            errors++; $display("FAIL s_y3: y=%0d sub=%0d cell=%0d want 3 3 0", s_y, s_y_sub, s_y_cell); end
        cyc(25);                                        // k = 100
        checks++; if (s_y !== 5'd4 || s_y_sub !== 2'd0 || s_y_cell !== 3'd1) begin
            errors++; $display("FAIL s_y4: y=%0d sub=%0d cell=%0d want 4 0 1", s_y, s_y_sub, s_y_cell); end
        cyc(24);                                        // k = 124
        checks++; if (s_line_irq !== 1'b0) begin errors++; $display("FAIL s_li_before: got %b want 0", s_line_irq); end
        cyc(1);                                         // k = 125 (y=5)
        checks++; if (s_line_irq !== LI) begin errors++; $display("FAIL s_li_hit: got %b want %b", s_line_irq, LI); end
        cyc(174);                                       // k = 299
        checks++; if (s_frame_irq !== 1'b0 || s_frame_cnt !== 8'd0) begin
            errors++; $display("FAIL s_pre_frame: fi=%b fc=%0d want 0 0", s_frame_irq, s_frame_cnt); end
        irq_clr = 1'b1;
        cyc(1);                                         // k = 300, set beats clear
        checks++; if (s_frame_irq !== 1'b1 || s_frame_cnt !== 8'd1 || s_blank !== 1'b1 || s_line_irq !== 1'b0) begin
            errors++; $display("FAIL s_frame_evt: fi=%b fc=%0d bl=%b li=%b want 1 1 1 0", s_frame_irq, s_frame_cnt, s_blank, s_line_irq); end
        cyc(1);
        checks++; if (s_frame_irq !== 1'b0) begin errors++; $display("FAIL s_irq_clr: got %b want 0", s_frame_irq); end
        irq_clr = 1'b0;
        cyc(23);                                        // k = 324
        checks++; if (s_vsync !== 1'b1) begin errors++; $display("FAIL s_vs_y12: got %b want 1", s_vsync); end
        cyc(1);
        checks++; if (s_vsync !== 1'b0) begin errors++; $display("FAIL s_vs_y13: got %b want 0", s_vsync); end
        cyc(49);
        checks++; if (s_vsync !== 1'b0) begin errors++; $display("FAIL s_vs_y14: got %b want 0", s_vsync); end
        cyc(1);
        checks++; if (s_vsync !== 1'b1) begin errors++; $display("FAIL s_vs_y15: got %b want 1", s_vsync); end
        cyc(74);                                        // k = 449
        checks++; if (s_y !== 5'd17 || s_y_cell !== 3'd4 || s_y_sub !== 2'd1 || s_x_cell !== 3'd6) begin
            errors++; $display("FAIL s_last: y=%0d ycell=%0d ysub=%0d xcell=%0d want 17 4 1 6", s_y, s_y_cell, s_y_sub, s_x_cell); end
        cyc(1);
        checks++; if (s_x !== 5'd0 || s_y !== 5'd0 || s_x_cell !== 3'd0 || s_x_sub !== 2'd0 || s_y_cell !== 3'd0 || s_y_sub !== 2'd0) begin
            errors++; $display("FAIL s_frame_wrap: x=%0d y=%0d cells=%0d/%0d/%0d/%0d want all 0",
                               s_x, s_y, s_x_cell, s_x_sub, s_y_cell, s_y_sub); end
        cyc(300);                                       // k = 750
        checks++; if (s_frame_cnt !== 8'd2 || s_frame_irq !== 1'b1) begin
            errors++; $display("FAIL s_frame2: fc=%0d fi=%b want 2 1", s_frame_cnt, s_frame_irq); end
    endtask

    task automatic test_enable;
        cyc(30);                                        // k = 780: y=13 x=5
        checks++; if (s_x !== 5'd5 || s_y !== 5'd13) begin
            errors++; $display("FAIL s_pre_en: x=%0d y=%0d want 5 13", s_x, s_y); end
        en_s = 1'b0;
        cyc(1);
        checks++; if (s_x !== 5'd0 || s_y !== 5'd0 || s_blank !== 1'b0 || s_hsync !== 1'b0 || s_vsync !== 1'b1) begin
            errors++; $display("FAIL s_en_off: x=%0d y=%0d bl=%b hs=%b vs=%b want 0 0 0 0 1", s_x, s_y, s_blank, s_hsync, s_vsync); end
        checks++; if (s_frame_cnt !== 8'd2 || s_frame_irq !== 1'b1 || s_line_irq !== LI) begin
            errors++; $display("FAIL s_en_hold: fc=%0d fi=%b li=%b want 2 1 %b", s_frame_cnt, s_frame_irq, s_line_irq, LI); end
        irq_clr = 1'b1;
        cyc(1);
        checks++; if (s_frame_irq !== 1'b0 || s_line_irq !== 1'b0 || s_x !== 5'd0) begin
            errors++; $display("FAIL s_en_clr: fi=%b li=%b x=%0d want 0 0 0", s_frame_irq, s_line_irq, s_x); end
        irq_clr = 1'b0;
        line_cmp_s = 5'd20;
        en_s = 1'b1;
        cyc(1);
        checks++; if (s_x !== 5'd1 || s_y !== 5'd0) begin
            errors++; $display("FAIL s_resume: x=%0d y=%0d want 1 0", s_x, s_y); end
        cyc(449);
        checks++; if (s_frame_cnt !== 8'd3 || s_frame_irq !== 1'b1 || s_line_irq !== 1'b0) begin
            errors++; $display("FAIL s_cmp_range: fc=%0d fi=%b li=%b want 3 1 0", s_frame_cnt, s_frame_irq, s_line_irq); end
    endtask

    initial begin
        rst_n      = 1'b0;
        irq_clr    = 1'b0;
        en_d       = 1'b1;
        en_s       = 1'b1;
        line_cmp_d = 10'd100;
        line_cmp_s = 5'd5;
        #1;
        test_reset;
        test_hline;
        test_small_frame;
        test_enable;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
